// File: rtl/sobel_window_gen.sv
// 3x3 sliding-window generator for a Sobel stage: two line buffers plus a 3x3 register window.
// Raster pixels are accepted on pix_valid; win_valid pulses once per complete in-image window.
module sobel_window_gen #(
  parameter int IMG_W = 8,
  parameter int PIX_W = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             frame_start,
  output logic [PIX_W-1:0] win1,
  output logic [PIX_W-1:0] win2,
  output logic [PIX_W-1:0] win3,
  output logic [PIX_W-1:0] win4,
  output logic [PIX_W-1:0] win5,
  output logic [PIX_W-1:0] win6,
  output logic [PIX_W-1:0] win7,
  output logic [PIX_W-1:0] win8,
  output logic [PIX_W-1:0] win9,
  output logic             win_valid
);

  localparam int CW = $clog2(IMG_W);

  logic [CW-1:0]    r_col;
  logic [1:0]       r_row;
  logic [PIX_W-1:0] r_lb0 [IMG_W];
  logic [PIX_W-1:0] r_lb1 [IMG_W];
  logic [PIX_W-1:0] r_win [9];
  logic             r_win_valid;

  logic [CW-1:0]    w_col_nxt;
  logic [1:0]       w_row_nxt;
  logic             w_win_ok;

  // Position bookkeeping; a frame_start pixel is itself (0,0), so it never yields a window.
  always_comb begin
    w_col_nxt = r_col;
    w_row_nxt = r_row;
    w_win_ok  = 1'b0;
    if (frame_start) begin
      w_col_nxt = CW'(1);
      w_row_nxt = 2'd0;
    end else if (r_col == CW'(IMG_W - 1)) begin
      w_col_nxt = CW'(0);
      w_row_nxt = (r_row == 2'd2) ? 2'd2 : (r_row + 2'd1);
      w_win_ok  = (r_row == 2'd2);
    end else begin
      w_col_nxt = r_col + CW'(1);
      w_row_nxt = r_row;
      w_win_ok  = (r_row == 2'd2) && (r_col >= CW'(2));
    end
  end

  // Counters, line buffers and window advance only on accepted pixels.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_col       <= CW'(0);
      r_row       <= 2'd0;
      r_win_valid <= 1'b0;
      for (int i = 0; i < IMG_W; i++) begin
        r_lb0[i] <= PIX_W'(0);
        r_lb1[i] <= PIX_W'(0);
      end
      for (int i = 0; i < 9; i++) begin
        r_win[i] <= PIX_W'(0);
      end
    end else if (pix_valid) begin
      r_col       <= w_col_nxt;
      r_row       <= w_row_nxt;
      r_win_valid <= w_win_ok;
      r_lb0[0]    <= pix_in;
      r_lb1[0]    <= r_lb0[IMG_W-1];
      for (int i = 1; i < IMG_W; i++) begin
        r_lb0[i] <= r_lb0[i-1];
        r_lb1[i] <= r_lb1[i-1];
      end
      // Shift left; the new right column is (row-2, row-1, row) at this column.
      r_win[0] <= r_win[1];
      r_win[1] <= r_win[2];
      r_win[2] <= r_lb1[IMG_W-1];
      r_win[3] <= r_win[4];
      r_win[4] <= r_win[5];
      r_win[5] <= r_lb0[IMG_W-1];
      r_win[6] <= r_win[7];
      r_win[7] <= r_win[8];
      r_win[8] <= pix_in;
    end else begin
      r_win_valid <= 1'b0;
    end
  end

  assign win1      = r_win[0];
  assign win2      = r_win[1];
  assign win3      = r_win[2];
  assign win4      = r_win[3];
  assign win5      = r_win[4];
  assign win6      = r_win[5];
  assign win7      = r_win[6];
  assign win8      = r_win[7];
  assign win9      = r_win[8];
  assign win_valid = r_win_valid;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: instance 0 uses IMG_W=4, instance 1 the default IMG_W=8.
// A pixel-history model predicts win_valid and the window every cycle; literal checks pin it.
module tb_sobel_window_gen;
  localparam int PW = 8;

  logic          clk;
  logic          rst_n [2];
  logic          pv    [2];
  logic [PW-1:0] pin   [2];
  logic          fs    [2];
  logic [PW-1:0] win   [2][9];
  logic          wv    [2];

  int n_tests = 0;
  int n_fail  = 0;
  int pulses [2];
  int rst_gen [2];
  int seen_gen [2];
  int hist [2][$];
  logic        exp_v [2];
  logic [71:0] exp_w [2];

  sobel_window_gen #(.IMG_W(4), .PIX_W(PW)) u_dut4 (
    .Clk(clk), .Rst_n(rst_n[0]), .pix_valid(pv[0]), .pix_in(pin[0]), .frame_start(fs[0]),
    .win1(win[0][0]), .win2(win[0][1]), .win3(win[0][2]), .win4(win[0][3]), .win5(win[0][4]),
    .win6(win[0][5]), .win7(win[0][6]), .win8(win[0][7]), .win9(win[0][8]), .win_valid(wv[0])
  );

  sobel_window_gen #(.PIX_W(PW)) u_dut8 (
    .Clk(clk), .Rst_n(rst_n[1]), .pix_valid(pv[1]), .pix_in(pin[1]), .frame_start(fs[1]),
    .win1(win[1][0]), .win2(win[1][1]), .win3(win[1][2]), .win4(win[1][3]), .win5(win[1][4]),
    .win6(win[1][5]), .win7(win[1][6]), .win8(win[1][7]), .win9(win[1][8]), .win_valid(wv[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wd(input int g);
    return (g == 0) ? 4 : 8;
  endfunction

  function automatic logic [71:0] packw(input int g);
    logic [71:0] v;
    v = 72'd0;
    for (int i = 0; i < 9; i++) v[71-8*i -: 8] = win[g][i];
    return v;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: every accepted pixel is appended to the frame history; position = index in history.
  always @(posedge clk) begin
    int k, r, c, w;
    for (int g = 0; g < 2; g++) begin
      if (rst_gen[g] != seen_gen[g] || !rst_n[g]) begin
        hist[g].delete();
        seen_gen[g] = rst_gen[g];
      end
      exp_v[g] = 1'b0;
      if (rst_n[g] && pv[g]) begin
        if (fs[g]) hist[g].delete();
        hist[g].push_back(int'(pin[g]));
        w = wd(g);
        k = hist[g].size() - 1;
        r = k / w;
        c = k % w;
        if (r >= 2 && c >= 2) begin
          exp_v[g] = 1'b1;
          for (int i = 0; i < 9; i++)
            exp_w[g][71-8*i -: 8] = PW'(hist[g][k - (2 - i/3)*w - (2 - i%3)]);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst_n[g]) begin
        chk($sformatf("win_valid[%0d]", g), {71'd0, wv[g]}, {71'd0, exp_v[g]});
        if (exp_v[g]) chk($sformatf("window[%0d]", g), packw(g), exp_w[g]);
        if (wv[g]) pulses[g]++;
      end
    end
  end

  task automatic step(input int g, input logic v, input logic [PW-1:0] p, input logic f);
    pv[g]  = v;
    pin[g] = p;
    fs[g]  = f;
    @(negedge clk);
    #1;
  endtask

  task automatic rst_pulse(input int g);
    rst_n[g] = 1'b0;
    rst_gen[g] = rst_gen[g] + 1;
    #1;
    chk($sformatf("async_rst_valid[%0d]", g), {71'd0, wv[g]}, 72'd0);
    chk($sformatf("async_rst_window[%0d]", g), packw(g), 72'd0);
    #1;
    rst_n[g] = 1'b1;
  endtask

  task automatic seq0();
    int p0;
    // basic frame and row-wrap edges
    p0 = pulses[0];
    for (int n = 0; n < 16; n++) begin
      step(0, 1'b1, PW'(n), n == 0);
      if (n == 10) begin
        chk("basic_first_valid", {71'd0, wv[0]}, 72'd1);
        chk("basic_first_window", packw(0), 72'h00_01_02_04_05_06_08_09_0A);
      end
      if (n == 12 || n == 13) chk("row_wrap_no_valid", {71'd0, wv[0]}, 72'd0);
    end
    chk("basic_pulse_count", 72'(pulses[0] - p0), 72'd4);
    // stall of 3 cycles after n=9
    p0 = pulses[0];
    for (int n = 0; n < 16; n++) begin
      step(0, 1'b1, PW'(n), n == 0);
      if (n == 9) begin
        for (int s = 0; s < 3; s++) begin
          step(0, 1'b0, PW'($urandom), 1'b0);
          chk("stall_no_valid", {71'd0, wv[0]}, 72'd0);
        end
      end
      if (n == 10) chk("stall_first_window", packw(0), 72'h00_01_02_04_05_06_08_09_0A);
    end
    chk("stall_pulse_count", 72'(pulses[0] - p0), 72'd4);
    // frame restart at n=6
    for (int n = 0; n < 6; n++) step(0, 1'b1, PW'(n), n == 0);
    p0 = pulses[0];
    for (int k = 0; k < 11; k++) begin
      step(0, 1'b1, PW'(8'h80 + k), k == 0);
      if (k == 9) chk("restart_quiet", 72'(pulses[0] - p0), 72'd0);
    end
    chk("restart_valid", {71'd0, wv[0]}, 72'd1);
    chk("restart_window", packw(0), 72'h80_81_82_84_85_86_88_89_8A);
    // async reset mid-frame
    for (int k = 11; k < 14; k++) step(0, 1'b1, PW'(8'h80 + k), 1'b0);
    rst_pulse(0);
    p0 = pulses[0];
    for (int k = 0; k < 10; k++) step(0, 1'b1, PW'($urandom), 1'b0);
    chk("post_reset_quiet", 72'(pulses[0] - p0), 72'd0);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(0, ($urandom % 4) != 0, PW'($urandom), ($urandom % 64) == 0);
      if (($urandom % 300) == 0) rst_pulse(0);
    end
    pv[0] = 1'b0;
  endtask

  task automatic seq1();
    int p1;
    p1 = pulses[1];
    for (int n = 0; n < 40; n++) begin
      step(1, 1'b1, PW'(n), n == 0);
      if (n == 18) chk("ramp_first_window", packw(1), 72'h00_01_02_08_09_0A_10_11_12);
    end
    chk("ramp_pulse_count", 72'(pulses[1] - p1), 72'd18);
    for (int i = 0; i < 1500; i++)
      step(1, ($urandom % 3) != 0, PW'($urandom), ($urandom % 100) == 0);
    pv[1] = 1'b0;
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      rst_n[g] = 1'b0;
      pv[g]    = 1'b0;
      pin[g]   = PW'(0);
      fs[g]    = 1'b0;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("reset_valid[%0d]", g), {71'd0, wv[g]}, 72'd0);
      chk($sformatf("reset_window[%0d]", g), packw(g), 72'd0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    fork
      seq0();
      seq1();
    join
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
